// File: rtl/alu_rsv_station.sv
// ============================================================================
// Module   : alu_rsv_station
// Purpose  : ALU reservation station. Holds dispatched ops until both operands
//            are captured (dispatch or CDB snoop), then issues one ready op per
//            cycle over an iss_req/iss_rdy handshake.
// Options  : `define RSV_AGE_ORDER_EN -> oldest-ready-first issue (age counters);
//            otherwise the lowest-index ready entry issues.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rsv_station #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 6,
    parameter int ROB_PTR_W = 4,
    parameter int OPC_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 dis_req,
    output logic                 dis_rdy,
    input  logic [OPC_W-1:0]     dis_opc,
    input  logic                 dis_src1_vld,
    input  logic [TAG_W-1:0]     dis_src1_tag,
    input  logic [31:0]          dis_src1_data,
    input  logic                 dis_src2_vld,
    input  logic [TAG_W-1:0]     dis_src2_tag,
    input  logic [31:0]          dis_src2_data,
    input  logic [TAG_W-1:0]     dis_tag,
    input  logic [ROB_PTR_W-1:0] dis_inst_id,
    input  logic                 cdb_vld,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [31:0]          cdb_wdata,
    output logic                 iss_req,
    input  logic                 iss_rdy,
    output logic [OPC_W-1:0]     iss_opc,
    output logic [31:0]          iss_src1,
    output logic [31:0]          iss_src2,
    output logic [TAG_W-1:0]     iss_tag,
    output logic [ROB_PTR_W-1:0] iss_inst_id
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     s1_rdy_q, s1_rdy_d;
    logic [DEPTH-1:0]     s2_rdy_q, s2_rdy_d;
    logic [OPC_W-1:0]     opc_q     [DEPTH];
    logic [OPC_W-1:0]     opc_d     [DEPTH];
    logic [TAG_W-1:0]     s1_tag_q  [DEPTH];
    logic [TAG_W-1:0]     s1_tag_d  [DEPTH];
    logic [TAG_W-1:0]     s2_tag_q  [DEPTH];
    logic [TAG_W-1:0]     s2_tag_d  [DEPTH];
    logic [31:0]          s1_data_q [DEPTH];
    logic [31:0]          s1_data_d [DEPTH];
    logic [31:0]          s2_data_q [DEPTH];
    logic [31:0]          s2_data_d [DEPTH];
    logic [TAG_W-1:0]     tag_q     [DEPTH];
    logic [TAG_W-1:0]     tag_d     [DEPTH];
    logic [ROB_PTR_W-1:0] id_q      [DEPTH];
    logic [ROB_PTR_W-1:0] id_d      [DEPTH];
`ifdef RSV_AGE_ORDER_EN
    logic [IDX_W-1:0]     age_q     [DEPTH];
    logic [IDX_W-1:0]     age_d     [DEPTH];
    logic [IDX_W-1:0]     vcnt_w;
    logic [IDX_W-1:0]     best_age_w;
`endif

    logic [DEPTH-1:0]     ready_w;
    logic [IDX_W-1:0]     sel_idx_w;
    logic [IDX_W-1:0]     free_idx_w;
    logic                 dis_fire_w;
    logic                 iss_fire_w;
    logic                 dis_s1_rdy_w, dis_s2_rdy_w;
    logic [31:0]          dis_s1_data_w, dis_s2_data_w;

    assign ready_w    = valid_q & s1_rdy_q & s2_rdy_q;
    assign dis_rdy    = ~&valid_q;
    assign iss_req    = |ready_w;
    assign dis_fire_w = dis_req & dis_rdy;
    assign iss_fire_w = iss_req & iss_rdy;

    // Tag 0 is x0; a same-cycle CDB hit is forwarded straight into the entry.
    assign dis_s1_rdy_w  = dis_src1_vld | (dis_src1_tag == '0) | (cdb_vld && cdb_tag == dis_src1_tag);
    assign dis_s2_rdy_w  = dis_src2_vld | (dis_src2_tag == '0) | (cdb_vld && cdb_tag == dis_src2_tag);
    assign dis_s1_data_w = dis_src1_vld ? dis_src1_data : ((dis_src1_tag == '0) ? 32'd0 : cdb_wdata);
    assign dis_s2_data_w = dis_src2_vld ? dis_src2_data : ((dis_src2_tag == '0) ? 32'd0 : cdb_wdata);

    always_comb begin
        free_idx_w = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx_w = IDX_W'(i);
        end
    end

`ifdef RSV_AGE_ORDER_EN
    always_comb begin
        sel_idx_w  = '0;
        best_age_w = '1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_w[i] && age_q[i] <= best_age_w) begin
                sel_idx_w  = IDX_W'(i);
                best_age_w = age_q[i];
            end
        end
    end
`else
    always_comb begin
        sel_idx_w = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_w[i]) sel_idx_w = IDX_W'(i);
        end
    end
`endif

    assign iss_opc     = iss_req ? opc_q[sel_idx_w]     : '0;
    assign iss_src1    = iss_req ? s1_data_q[sel_idx_w] : '0;
    assign iss_src2    = iss_req ? s2_data_q[sel_idx_w] : '0;
    assign iss_tag     = iss_req ? tag_q[sel_idx_w]     : '0;
    assign iss_inst_id = iss_req ? id_q[sel_idx_w]      : '0;

    always_comb begin
        valid_d  = valid_q;
        s1_rdy_d = s1_rdy_q;
        s2_rdy_d = s2_rdy_q;
        for (int i = 0; i < DEPTH; i++) begin
            opc_d[i]     = opc_q[i];
            s1_tag_d[i]  = s1_tag_q[i];
            s2_tag_d[i]  = s2_tag_q[i];
            s1_data_d[i] = s1_data_q[i];
            s2_data_d[i] = s2_data_q[i];
            tag_d[i]     = tag_q[i];
            id_d[i]      = id_q[i];
`ifdef RSV_AGE_ORDER_EN
            age_d[i]     = age_q[i];
`endif
        end
`ifdef RSV_AGE_ORDER_EN
        vcnt_w = '0;
        for (int i = 0; i < DEPTH; i++) vcnt_w = vcnt_w + IDX_W'(valid_q[i]);
`endif

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && cdb_vld) begin
                if (!s1_rdy_q[i] && s1_tag_q[i] == cdb_tag) begin
                    s1_rdy_d[i]  = 1'b1;
                    s1_data_d[i] = cdb_wdata;
                end
                if (!s2_rdy_q[i] && s2_tag_q[i] == cdb_tag) begin
                    s2_rdy_d[i]  = 1'b1;
                    s2_data_d[i] = cdb_wdata;
                end
            end
        end

        if (iss_fire_w) begin
            valid_d[sel_idx_w] = 1'b0;
`ifdef RSV_AGE_ORDER_EN
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && age_q[i] > age_q[sel_idx_w]) age_d[i] = age_q[i] - 1'b1;
            end
`endif
        end

        // The free slot comes from registered state, so it never aliases the issuing slot.
        if (dis_fire_w) begin
            valid_d[free_idx_w]   = 1'b1;
            opc_d[free_idx_w]     = dis_opc;
            s1_rdy_d[free_idx_w]  = dis_s1_rdy_w;
            s1_tag_d[free_idx_w]  = dis_src1_tag;
            s1_data_d[free_idx_w] = dis_s1_data_w;
            s2_rdy_d[free_idx_w]  = dis_s2_rdy_w;
            s2_tag_d[free_idx_w]  = dis_src2_tag;
            s2_data_d[free_idx_w] = dis_s2_data_w;
            tag_d[free_idx_w]     = dis_tag;
            id_d[free_idx_w]      = dis_inst_id;
`ifdef RSV_AGE_ORDER_EN
            age_d[free_idx_w]     = vcnt_w - IDX_W'(iss_fire_w);
`endif
        end

        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opc_q[i]     <= '0;
                s1_tag_q[i]  <= '0;
                s2_tag_q[i]  <= '0;
                s1_data_q[i] <= '0;
                s2_data_q[i] <= '0;
                tag_q[i]     <= '0;
                id_q[i]      <= '0;
`ifdef RSV_AGE_ORDER_EN
                age_q[i]     <= '0;
`endif
            end
        end else begin
            valid_q  <= valid_d;
            s1_rdy_q <= s1_rdy_d;
            s2_rdy_q <= s2_rdy_d;
            for (int i = 0; i < DEPTH; i++) begin
                opc_q[i]     <= opc_d[i];
                s1_tag_q[i]  <= s1_tag_d[i];
                s2_tag_q[i]  <= s2_tag_d[i];
                s1_data_q[i] <= s1_data_d[i];
                s2_data_q[i] <= s2_data_d[i];
                tag_q[i]     <= tag_d[i];
                id_q[i]      <= id_d[i];
`ifdef RSV_AGE_ORDER_EN
                age_q[i]     <= age_d[i];
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_rsv_station.sv
// ============================================================================
// Module   : tb_alu_rsv_station
// Purpose  : Directed scoreboard bench for alu_rsv_station (default build).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_rsv_station;

    logic        clk = 1'b0;
    logic        rst, flush, dis_req, dis_rdy;
    logic [3:0]  dis_opc;
    logic        dis_src1_vld, dis_src2_vld;
    logic [5:0]  dis_src1_tag, dis_src2_tag, dis_tag;
    logic [31:0] dis_src1_data, dis_src2_data;
    logic [3:0]  dis_inst_id;
    logic        cdb_vld;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_wdata;
    logic        iss_req, iss_rdy;
    logic [3:0]  iss_opc;
    logic [31:0] iss_src1, iss_src2;
    logic [5:0]  iss_tag;
    logic [3:0]  iss_inst_id;

    typedef struct packed {
        logic [3:0]  opc;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [5:0]  tag;
        logic [3:0]  id;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_rsv_station dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dis_req(dis_req), .dis_rdy(dis_rdy), .dis_opc(dis_opc),
        .dis_src1_vld(dis_src1_vld), .dis_src1_tag(dis_src1_tag), .dis_src1_data(dis_src1_data),
        .dis_src2_vld(dis_src2_vld), .dis_src2_tag(dis_src2_tag), .dis_src2_data(dis_src2_data),
        .dis_tag(dis_tag), .dis_inst_id(dis_inst_id),
        .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
        .iss_req(iss_req), .iss_rdy(iss_rdy), .iss_opc(iss_opc),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_tag(iss_tag), .iss_inst_id(iss_inst_id)
    );

    // Monitor: every handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t got, exp;
        if (!rst && iss_req && iss_rdy) begin
            total++;
            got = '{iss_opc, iss_src1, iss_src2, iss_tag, iss_inst_id};
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected got=%h required=none", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL issue_data got=%h required=%h", got, exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic disp(input logic [3:0] opc,
                        input logic v1, input logic [5:0] t1, input logic [31:0] d1,
                        input logic v2, input logic [5:0] t2, input logic [31:0] d2,
                        input logic [5:0] tag, input logic [3:0] id);
        dis_req = 1'b1; dis_opc = opc;
        dis_src1_vld = v1; dis_src1_tag = t1; dis_src1_data = d1;
        dis_src2_vld = v2; dis_src2_tag = t2; dis_src2_data = d2;
        dis_tag = tag; dis_inst_id = id;
    endtask

    task automatic cdb(input logic v, input logic [5:0] t, input logic [31:0] d);
        cdb_vld = v; cdb_tag = t; cdb_wdata = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; iss_rdy = 1'b0;
        disp(4'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 6'd0, 4'd0);
        dis_req = 1'b0;
        cdb(1'b0, 6'd0, 32'd0);
        step(); step();
        rst = 1'b0;
        chk("reset_dis_rdy", 32'(dis_rdy), 32'd1);
        chk("reset_iss_req", 32'(iss_req), 32'd0);
        chk("reset_iss_src1", iss_src1, 32'd0);

        // Both operands present at dispatch.
        iss_rdy = 1'b1;
        disp(4'd0, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 6'd3, 4'd1);
        sb.push_back('{4'd0, 32'd5, 32'd7, 6'd3, 4'd1});
        step(); dis_req = 1'b0;
        chk("t1_iss_req", 32'(iss_req), 32'd1);
        step();
        chk("t1_freed", 32'(iss_req), 32'd0);

        // Wakeup through a later CDB broadcast.
        disp(4'd1, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd2, 6'd10, 4'd2);
        step(); dis_req = 1'b0;
        chk("t2_wait0", 32'(iss_req), 32'd0);
        step();
        cdb(1'b1, 6'd9, 32'h1234);
        chk("t2_wait_bcast", 32'(iss_req), 32'd0);
        sb.push_back('{4'd1, 32'h1234, 32'd2, 6'd10, 4'd2});
        step(); cdb(1'b0, 6'd0, 32'd0);
        chk("t2_iss_req", 32'(iss_req), 32'd1);
        step();

        // Same-cycle CDB forward into a dispatching op.
        disp(4'd2, 1'b1, 6'd0, 32'd11, 1'b0, 6'd4, 32'd0, 6'd12, 4'd3);
        cdb(1'b1, 6'd4, 32'hDEAD);
        sb.push_back('{4'd2, 32'd11, 32'hDEAD, 6'd12, 4'd3});
        step(); dis_req = 1'b0; cdb(1'b0, 6'd0, 32'd0);
        chk("t3_iss_req", 32'(iss_req), 32'd1);
        step();

        // Fill all entries, then try a fifth dispatch.
        iss_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(4'(i + 1), 1'b0, 6'(20 + i), 32'd0, 1'b1, 6'd0, 32'(100 + i), 6'(30 + i), 4'(4 + i));
            step();
        end
        chk("t4_full", 32'(dis_rdy), 32'd0);
        disp(4'd9, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1, 6'd40, 4'd15);
        step(); dis_req = 1'b0;
        chk("t4_ignored", 32'(iss_req), 32'd0);
        cdb(1'b1, 6'd21, 32'h55);
        step(); cdb(1'b0, 6'd0, 32'd0);
        chk("t4_woken", 32'(iss_req), 32'd1);
        sb.push_back('{4'd2, 32'h55, 32'd101, 6'd31, 4'd5});
        iss_rdy = 1'b1;
        chk("t4_rdy_same_cycle", 32'(dis_rdy), 32'd0);
        step(); iss_rdy = 1'b0;
        chk("t4_rdy_after", 32'(dis_rdy), 32'd1);

        // Stall: outputs held while the ALU is not ready.
        cdb(1'b1, 6'd20, 32'h66);
        step(); cdb(1'b0, 6'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_hold_req", 32'(iss_req), 32'd1);
            chk("t5_hold_src1", iss_src1, 32'h66);
            chk("t5_hold_id", 32'(iss_inst_id), 32'd4);
            step();
        end
        sb.push_back('{4'd1, 32'h66, 32'd100, 6'd30, 4'd4});
        iss_rdy = 1'b1;
        step(); iss_rdy = 1'b0;
        chk("t5_once", 32'(iss_req), 32'd0);

        // Flush with three valid entries and a same-cycle dispatch.
        disp(4'd3, 1'b0, 6'd24, 32'd0, 1'b1, 6'd0, 32'd7, 6'd34, 4'd8);
        step();
        disp(4'd4, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2, 6'd50, 4'd9);
        flush = 1'b1;
        step(); flush = 1'b0; dis_req = 1'b0;
        chk("t6_iss_req", 32'(iss_req), 32'd0);
        chk("t6_dis_rdy", 32'(dis_rdy), 32'd1);
        iss_rdy = 1'b1;
        for (int i = 22; i < 25; i++) begin
            cdb(1'b1, 6'(i), 32'(i));
            step();
            chk("t6_no_issue", 32'(iss_req), 32'd0);
        end
        cdb(1'b0, 6'd0, 32'd0);

        // Reset in the middle of a pending issue.
        iss_rdy = 1'b0;
        disp(4'd5, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4, 6'd60, 4'd10);
        step(); dis_req = 1'b0;
        chk("t7_pending", 32'(iss_req), 32'd1);
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("t7_rst_req", 32'(iss_req), 32'd0);
        chk("t7_rst_src1", iss_src1, 32'd0);
        chk("t7_rst_dis_rdy", 32'(dis_rdy), 32'd1);

        step(); step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
